// File: rtl/sdram_burst_master_4bit_pkg.sv
// rtl/sdram_burst_master_4bit_pkg.sv - shared types and size defaults for the 4-bit SDRAM burst master
// Contents: state_t (IDLE/WRITE/READ), default ADDR_W/DATA_W/LEN_W, MEM_DEPTH.
package sdram_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;
  localparam int LEN_W_DEF  = 4;
  localparam int MEM_DEPTH  = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_burst_master_4bit_if.sv
// rtl/sdram_burst_master_4bit_if.sv - host request/stream and memory-port bundle for the burst master
// Signals: req_* (burst request handshake), wr_* (write stream), rd_* (read stream),
//          done/busy (status), mem_* (16x4 synchronous memory port).
// Modports: master = burst master side, slave = host/memory side.
interface sdram_burst_master_4bit_if
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              done;
  logic              busy;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    input  req_valid, req_write, req_addr, req_len,
    input  wr_data, wr_valid,
    input  mem_dout,
    output req_ready, wr_ready,
    output rd_data, rd_valid,
    output done, busy,
    output mem_we, mem_addr, mem_din
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len,
    output wr_data, wr_valid,
    output mem_dout,
    input  req_ready, wr_ready,
    input  rd_data, rd_valid,
    input  done, busy,
    input  mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/sdram_controller_4bit.sv
// rtl/sdram_controller_4bit.sv - 16x4 synchronous memory with registered read port
// Ports: clk; we (write enable, commits on rising edge); addr; din (write data);
//        dout (mem[addr] registered one cycle after an address with we=0).
module sdram_controller_4bit
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read port only updates on non-write cycles, so dout holds the last read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/sdram_burst_master_4bit.sv
// rtl/sdram_burst_master_4bit.sv - burst initiator sequencing host bursts into single-word memory accesses
// Ports: clk; rst (synchronous, active-high);
//        bus (master modport): req_* request handshake, wr_* write stream,
//        rd_* read stream (no backpressure), done pulse, busy, mem_* memory port.
module sdram_burst_master_4bit
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input logic                        clk,
  input logic                        rst,
  sdram_burst_master_4bit_if.master  bus
);

  localparam logic [DATA_W-1:0] ZERO_DATA = '0;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cur_addr, cur_addr_next;
  logic [LEN_W-1:0]  count, count_next;
  logic              rd_pend, rd_pend_next;
  logic              done_pulse, done_next;
  logic              beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      count      <= '0;
      rd_pend    <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      cur_addr   <= cur_addr_next;
      count      <= count_next;
      rd_pend    <= rd_pend_next;
      done_pulse <= done_next;
    end
  end

  // count holds "words remaining minus one", so the access issued with
  // count==0 is the last of the burst.
  always_comb begin
    state_next    = state;
    cur_addr_next = cur_addr;
    count_next    = count;
    rd_pend_next  = 1'b0;
    done_next     = 1'b0;
    beat          = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cur_addr_next = bus.req_addr;
          count_next    = bus.req_len;
          state_next    = bus.req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (bus.wr_valid) begin
          beat          = 1'b1;
          cur_addr_next = cur_addr + 1'b1;
          count_next    = count - 1'b1;
          if (count == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      READ: begin
        // One address per cycle; the data returns a cycle later, which is
        // exactly when rd_pend is high.
        rd_pend_next  = 1'b1;
        cur_addr_next = cur_addr + 1'b1;
        count_next    = count - 1'b1;
        if (count == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.wr_ready  = (state == WRITE) && !rst;
  // Gating with rst keeps a reset mid-write from committing the current beat.
  assign bus.mem_we    = beat && !rst;
  assign bus.mem_addr  = cur_addr;
  assign bus.mem_din   = (beat && !rst) ? bus.wr_data : ZERO_DATA;
  assign bus.rd_valid  = rd_pend;
  assign bus.rd_data   = bus.mem_dout;
  assign bus.done      = done_pulse;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_sdram_burst_master_4bit.sv
// tb/tb_sdram_burst_master_4bit.sv - scoreboard bench for the 4-bit SDRAM burst master
module tb_sdram_burst_master_4bit;
  import sdram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_burst_master_4bit_if bus ();

  sdram_burst_master_4bit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sdram_controller_4bit u_mem (
    .clk  (clk),
    .we   (bus.mem_we),
    .addr (bus.mem_addr),
    .din  (bus.mem_din),
    .dout (bus.mem_dout)
  );

  int total = 0;
  int bad   = 0;

  // Reference memory contents and expected read-stream words.
  logic [3:0] ref_mem [16];
  logic [3:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Read-stream monitor: every rd_valid beat must match the next expected word.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_req(input bit wr, input int addr, input int len);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr[3:0];
    bus.req_len   = len[3:0];
    @(negedge clk);
    check("req_ready", int'(bus.req_ready), 1);
    next_cycle();
    bus.req_valid = 1'b0;
    if (!wr)
      for (int i = 0; i <= len; i++) exp_q.push_back(ref_mem[(addr + i) % 16]);
  endtask

  // pattern < 0: random data; otherwise word i = (pattern + i) mod 16.
  // abort_at >= 0: assert rst in the cycle that would carry that beat.
  task automatic do_write(input int addr, input int len, input int stall,
                          input bit accepted, input int abort_at, input int pattern);
    logic [3:0] d;
    if (!accepted) offer_req(1'b1, addr, len);
    for (int i = 0; i <= len; i++) begin
      if (i > 0) begin
        for (int s = 0; s < stall; s++) begin
          bus.wr_valid = 1'b0;
          @(negedge clk);
          check("stall_we", int'(bus.mem_we), 0);
          check("stall_done", int'(bus.done), 0);
          next_cycle();
        end
      end
      d = (pattern < 0) ? 4'($urandom_range(0, 15)) : 4'((pattern + i) % 16);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      if (i == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst_we", int'(bus.mem_we), 0);
        next_cycle();
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("rst_no_done", int'(bus.done), 0);
        check("rst_ready", int'(bus.req_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        next_cycle();
        return;
      end
      @(negedge clk);
      check("wr_we", int'(bus.mem_we), 1);
      check("wr_addr", int'(bus.mem_addr), (addr + i) % 16);
      check("wr_din", int'(bus.mem_din), int'(d));
      check("wr_early_done", int'(bus.done), 0);
      next_cycle();
      ref_mem[(addr + i) % 16] = d;
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    check("wr_done", int'(bus.done), 1);
    check("wr_busy_after", int'(bus.busy), 0);
    check("wr_we_after", int'(bus.mem_we), 0);
    next_cycle();
  endtask

  // Cycle k counts from the accept edge: data appears from k=2, last word with done at k=len+2.
  // b2b: offer a write request in the done cycle; it is left accepted on return.
  task automatic do_read(input int addr, input int len, input bit b2b,
                         input int b_addr, input int b_len);
    offer_req(1'b0, addr, len);
    for (int k = 1; k <= len + 2; k++) begin
      if (b2b && k == len + 2) begin
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = b_addr[3:0];
        bus.req_len   = b_len[3:0];
      end
      @(negedge clk);
      check("rd_valid_timing", int'(bus.rd_valid), (k >= 2) ? 1 : 0);
      check("rd_done_timing", int'(bus.done), (k == len + 2) ? 1 : 0);
      if (b2b && k == len + 2) check("b2b_ready", int'(bus.req_ready), 1);
      next_cycle();
    end
    bus.req_valid = 1'b0;
    if (!b2b) begin
      @(negedge clk);
      check("rd_valid_end", int'(bus.rd_valid), 0);
      check("rd_busy_end", int'(bus.busy), 0);
      next_cycle();
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    rst = 1'b1;

    next_cycle();
    @(negedge clk);
    check("reset_req_ready", int'(bus.req_ready), 0);
    check("reset_we", int'(bus.mem_we), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_rd_valid", int'(bus.rd_valid), 0);
    check("reset_done", int'(bus.done), 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_req_ready", int'(bus.req_ready), 1);
    check("post_reset_busy", int'(bus.busy), 0);
    check("post_reset_wr_ready", int'(bus.wr_ready), 0);
    check("post_reset_rd_valid", int'(bus.rd_valid), 0);
    next_cycle();

    // Full burst: fill memory with its own address, read it all back.
    do_write(0, 15, 0, 1'b0, -1, 0);
    do_read(0, 15, 1'b0, 0, 0);

    // Wrap: 14,15,0,1 with data A,B,C,D.
    do_write(14, 3, 0, 1'b0, -1, 10);
    do_read(14, 3, 1'b0, 0, 0);

    // Stalled write of two words, then confirm neighbours untouched.
    do_write(0, 1, 3, 1'b0, -1, -1);
    do_read(0, 3, 1'b0, 0, 0);

    // Reset during the third beat of a 4-word write at 4.
    do_write(4, 3, 0, 1'b0, 2, -1);
    do_read(4, 3, 1'b0, 0, 0);

    // Back-to-back: write to the last read address accepted in the done cycle.
    do_read(8, 2, 1'b1, 10, 1);
    do_write(10, 1, 0, 1'b1, -1, -1);
    do_read(8, 4, 1'b0, 0, 0);

    // Randomized bursts.
    for (int n = 0; n < 24; n++) begin
      int a, l;
      a = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, l, int'($urandom_range(0, 2)), 1'b0, -1, -1);
      else do_read(a, l, 1'b0, 0, 0);
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    repeat (3) next_cycle();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
